remote_comm: RTL and testbench
==============================

// Module: remote_comm
// PURPOSE
//  Host-side UART master that emulates the remote controller of the quadcopter.
//  On request it serialises a 3-byte packet (cmd, data[15:8], data[7:0]) on TX.
//  It receives the 1-byte response the flight controller returns on RX.
//  Sits in benches and host bridges, wired TX->copter RX and RX<-copter TX.
// PARAMETERS
//  BAUD_DIV   2604  clocks per UART bit (50 MHz / 19200 baud)
// PORTS
//  clk           in   1   single system clock, all logic on posedge
//  rst_n         in   1   asynchronous active-low reset
//  RX            in   1   serial in from the copter (idle high)
//  TX            out  1   serial out to the copter (idle high)
//  cmd           in   8   command byte to send
//  data          in   16  payload, sent MSB byte first
//  send_cmd      in   1   one-cycle pulse: start a packet
//  cmd_sent      out  1   packet fully transmitted
//  resp          out  8   last received response byte
//  resp_rdy      out  1   resp holds a fresh byte
//  clr_resp_rdy  in   1   one-cycle pulse: knock down resp_rdy
// BEHAVIOUR
//  - Reset: TX=1, cmd_sent=0, resp_rdy=0, resp=8'h00, all FSMs IDLE.
//  - Framing: 8N1, LSB first. Each bit lasts exactly BAUD_DIV clocks.
//  - Packet FSM states: IDLE, HIGH, MID, LOW, DONE.
//  - IDLE + send_cmd: latch cmd/data, clear cmd_sent, start byte cmd next cycle.
//  - HIGH sends data[15:8]. MID sends data[7:0]. LOW is a spare-free alias, so each
//    byte starts the cycle after the previous stop bit ends; no idle gap.
//  - After the third stop bit completes, set cmd_sent (level).
//  - cmd_sent stays set until the next accepted send_cmd.
//  - send_cmd while a packet is in flight is ignored; latched values are unchanged.
//  - RX path: 2-flop synchroniser, then start detect on a high->low edge.
//  - Re-check mid-bit at BAUD_DIV/2; return to idle if RX is high (glitch).
//  - Sample each data bit at mid-bit. The stop bit is waited out but not checked.
//  - Byte complete: load resp and set resp_rdy.
//  - resp_rdy clears on clr_resp_rdy or on detection of a new start bit.
//  - If a set and a clear coincide, the set wins.
//  - Response semantics (informational, no logic): 8'hA5 = positive ack.
//    Any other value = nack/garbage.
//  - TX and RX are fully independent (full duplex).
//  - Async reset mid-packet aborts immediately to the reset state.
// CONFIGURATION
//  REMOTE_COMM_ACK_FLAG_EN
//   defined: adds output ack_ok (1 bit).
//    ack_ok is registered and updated with resp; 1 iff received byte == 8'hA5.
//    ack_ok resets to 0.
//   undefined: port and logic absent; behaviour otherwise identical.
// STRUCTURE
//  Package remote_comm_pkg holds:
//   - command codes: STPTCH=8'h02, STRLL=8'h03, STYW=8'h04, STTHRST=8'h05,
//     CAL=8'h06, EMER=8'h07, MTSOFF=8'h08
//   - POS_ACK=8'hA5
//   - packet FSM state enum
//  Sub-module uart_trx: byte-level UART TX/RX.
//   - TX side: trmt, tx_data, tx_done
//   - RX side: rx_data, rdy, clr_rdy
//  remote_comm holds only the packet FSM, the latches and cmd_sent.
// TESTING
//  - Reset: TX=1, cmd_sent=0, resp_rdy=0 held through reset.
//  - send cmd=8'h06, data=16'h0000 with BAUD_DIV=16:
//    -> TX shows 06,00,00 back-to-back, 30 bit times.
//    -> cmd_sent rises 480 clocks after start.
//  - cmd=8'hED, data=16'hBEEF: decoded bytes ED,BE,EF in order.
//    A second send_cmd mid-packet is ignored.
//  - Drive RX with byte 8'hA5 -> resp=A5, resp_rdy=1.
//    clr_resp_rdy pulse -> 0. With macro, ack_ok=1.
//  - RX byte 8'h5A -> resp=5A (ack_ok=0). A 3-clock low glitch on RX produces no byte.
//  - Reset asserted mid-packet -> TX=1 at once; a fresh send_cmd then sends a full packet.

Source files
------------

// File: rtl/remote_comm_pkg.sv
// Shared constants and state types for the remote controller UART master.
// Command codes, positive-ack value, packet and receiver FSM encodings.
package remote_comm_pkg;

  localparam logic [7:0] STPTCH  = 8'h02;
  localparam logic [7:0] STRLL   = 8'h03;
  localparam logic [7:0] STYW    = 8'h04;
  localparam logic [7:0] STTHRST = 8'h05;
  localparam logic [7:0] CAL     = 8'h06;
  localparam logic [7:0] EMER    = 8'h07;
  localparam logic [7:0] MTSOFF  = 8'h08;

  localparam logic [7:0] POS_ACK = 8'hA5;

  typedef enum logic [2:0] {StIdle, StHigh, StMid, StLow, StDone} pkt_state_e;

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

endpackage

// File: rtl/uart_trx.sv
// Byte-level 8N1 UART, independent transmitter and receiver, BAUD_DIV clocks per bit.
// tx_done is high in the last clock of the stop bit so a new trmt can follow with no gap.
module uart_trx
  import remote_comm_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx_done,
  output logic       TX,
  input  logic       RX,
  output logic [7:0] rx_data,
  output logic       rdy,
  input  logic       clr_rdy
);

  localparam int unsigned CntW = $clog2(BAUD_DIV);
  localparam logic [CntW-1:0] BaudLast = CntW'(BAUD_DIV - 1);
  localparam logic [CntW-1:0] BaudHalf = CntW'(BAUD_DIV / 2 - 1);

  // Transmitter
  logic            tx_busy_q, tx_busy_d;
  logic [9:0]      tx_shift_q, tx_shift_d;
  logic [3:0]      tx_bit_q, tx_bit_d;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d;

  assign tx_done = tx_busy_q && (tx_cnt_q == BaudLast) && (tx_bit_q == 4'd9);
  assign TX      = tx_busy_q ? tx_shift_q[0] : 1'b1;

  always_comb begin
    tx_busy_d  = tx_busy_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    tx_cnt_d   = tx_cnt_q;
    if (trmt && (!tx_busy_q || tx_done)) begin
      tx_busy_d  = 1'b1;
      tx_shift_d = {1'b1, tx_data, 1'b0};
      tx_bit_d   = '0;
      tx_cnt_d   = '0;
    end else if (tx_busy_q) begin
      if (tx_cnt_q == BaudLast) begin
        tx_cnt_d   = '0;
        tx_shift_d = {1'b1, tx_shift_q[9:1]};
        tx_bit_d   = tx_bit_q + 1'b1;
        if (tx_bit_q == 4'd9) tx_busy_d = 1'b0;
      end else begin
        tx_cnt_d = tx_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy_q  <= 1'b0;
      tx_shift_q <= '1;
      tx_bit_q   <= '0;
      tx_cnt_q   <= '0;
    end else begin
      tx_busy_q  <= tx_busy_d;
      tx_shift_q <= tx_shift_d;
      tx_bit_q   <= tx_bit_d;
      tx_cnt_q   <= tx_cnt_d;
    end
  end

  // Receiver
  rx_state_e       rx_state_q, rx_state_d;
  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rdy_q, rdy_d;
  logic            start_det, byte_done;

  assign start_det = (rx_state_q == RxIdle) && rx_prev_q && !rx_sync_q;
  assign rx_data   = rx_data_q;
  assign rdy       = rdy_q;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    byte_done  = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        if (start_det) begin
          rx_state_d = RxStart;
          rx_cnt_d   = '0;
        end
      end
      RxStart: begin
        // Start bit must still be low at mid-bit, otherwise it was a glitch.
        if (rx_cnt_q == BaudHalf) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RxIdle : RxData;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RxData: begin
        if (rx_cnt_q == BaudLast) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) rx_state_d = RxStop;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RxStop: begin
        if (rx_cnt_q == BaudLast) begin
          rx_data_d  = rx_shift_q;
          byte_done  = 1'b1;
          rx_state_d = RxIdle;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RxIdle;
    endcase

    if (byte_done) begin
      rdy_d = 1'b1;
    end else if (clr_rdy || start_det) begin
      rdy_d = 1'b0;
    end else begin
      rdy_d = rdy_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rdy_q      <= 1'b0;
    end else begin
      rx_meta_q  <= RX;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rdy_q      <= rdy_d;
    end
  end

endmodule

// File: rtl/remote_comm.sv
// Host-side remote controller: sends 3-byte packets (cmd, data hi, data lo), receives a response.
// Optional ack_ok output enabled by defining REMOTE_COMM_ACK_FLAG_EN.
module remote_comm
  import remote_comm_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  input  logic [7:0]  cmd,
  input  logic [15:0] data,
  input  logic        send_cmd,
  output logic        cmd_sent,
  output logic [7:0]  resp,
  output logic        resp_rdy,
  input  logic        clr_resp_rdy
`ifdef REMOTE_COMM_ACK_FLAG_EN
  ,
  output logic        ack_ok
`endif
);

  pkt_state_e  state_q, state_d;
  logic [15:0] data_q, data_d;
  logic        cmd_sent_q, cmd_sent_d;
  logic        trmt, tx_done;
  logic [7:0]  tx_data;

  uart_trx #(
    .BAUD_DIV(BAUD_DIV)
  ) u_uart_trx (
    .clk     (clk),
    .rst_n   (rst_n),
    .trmt    (trmt),
    .tx_data (tx_data),
    .tx_done (tx_done),
    .TX      (TX),
    .RX      (RX),
    .rx_data (resp),
    .rdy     (resp_rdy),
    .clr_rdy (clr_resp_rdy)
  );

  // Each state hands the UART its byte in the last clock of the previous stop bit.
  // The cmd byte goes straight into the UART shift register, which acts as its latch.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    cmd_sent_d = cmd_sent_q;
    trmt       = 1'b0;
    tx_data    = cmd;
    unique case (state_q)
      StIdle, StDone: begin
        if (send_cmd) begin
          trmt       = 1'b1;
          data_d     = data;
          cmd_sent_d = 1'b0;
          state_d    = StHigh;
        end
      end
      StHigh: begin
        if (tx_done) begin
          trmt    = 1'b1;
          tx_data = data_q[15:8];
          state_d = StMid;
        end
      end
      StMid: begin
        if (tx_done) begin
          trmt    = 1'b1;
          tx_data = data_q[7:0];
          state_d = StLow;
        end
      end
      StLow: begin
        if (tx_done) begin
          cmd_sent_d = 1'b1;
          state_d    = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      data_q     <= '0;
      cmd_sent_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      cmd_sent_q <= cmd_sent_d;
    end
  end

  assign cmd_sent = cmd_sent_q;

`ifdef REMOTE_COMM_ACK_FLAG_EN
  logic ack_ok_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_ok_q <= 1'b0;
    end else begin
      ack_ok_q <= (resp == POS_ACK);
    end
  end

  assign ack_ok = ack_ok_q;
`endif

endmodule

// File: tb/tb_remote_comm.sv
// Scoreboard bench for remote_comm: TX frames and RX responses checked by independent monitors.
module tb_remote_comm;
  import remote_comm_pkg::*;

  localparam int unsigned BAUD = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic        TX;
  logic [7:0]  cmd = 8'h00;
  logic [15:0] data = 16'h0000;
  logic        send_cmd = 1'b0;
  logic        cmd_sent;
  logic [7:0]  resp;
  logic        resp_rdy;
  logic        clr_resp_rdy = 1'b0;
`ifdef REMOTE_COMM_ACK_FLAG_EN
  logic        ack_ok;
`endif

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  tx_exp_q[$];
  logic [7:0]  rx_exp_q[$];
  logic        discard = 1'b0;

  always #5 clk = ~clk;

  remote_comm #(
    .BAUD_DIV(BAUD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .RX           (RX),
    .TX           (TX),
    .cmd          (cmd),
    .data         (data),
    .send_cmd     (send_cmd),
    .cmd_sent     (cmd_sent),
    .resp         (resp),
    .resp_rdy     (resp_rdy),
    .clr_resp_rdy (clr_resp_rdy)
`ifdef REMOTE_COMM_ACK_FLAG_EN
    ,
    .ack_ok       (ack_ok)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_pkt(input logic [7:0] c, input logic [15:0] d);
    @(negedge clk);
    cmd      = c;
    data     = d;
    send_cmd = 1'b1;
    tx_exp_q.push_back(c);
    tx_exp_q.push_back(d[15:8]);
    tx_exp_q.push_back(d[7:0]);
    @(negedge clk);
    send_cmd = 1'b0;
  endtask

  task automatic wait_sent(output int cyc);
    cyc = 0;
    while (!cmd_sent && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic drive_rx(input logic [7:0] b);
    rx_exp_q.push_back(b);
    @(negedge clk);
    RX = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (BAUD) @(negedge clk);
    end
    RX = 1'b1;
    repeat (BAUD) @(negedge clk);
  endtask

  // TX monitor: decode 8N1 frames at mid-bit and compare with the expected byte queue
  initial begin
    logic [7:0] b;
    logic       stop;
    forever begin
      @(negedge clk);
      if (rst_n && TX === 1'b0) begin
        repeat (BAUD / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BAUD) @(negedge clk);
          b[i] = TX;
        end
        repeat (BAUD) @(negedge clk);
        stop = TX;
        if (discard) begin
          discard = 1'b0;
        end else if (tx_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected: got %0h expected none", b);
        end else begin
          check("tx_byte", {24'h0, b}, {24'h0, tx_exp_q.pop_front()});
          check("tx_stop", {31'h0, stop}, 32'h1);
        end
      end
    end
  end

  // RX monitor: every rising resp_rdy must match the next expected response
  initial begin
    logic prev = 1'b0;
    forever begin
      @(negedge clk);
      if (resp_rdy && !prev) begin
        if (rx_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected: got %0h expected none", resp);
        end else begin
          check("resp", {24'h0, resp}, {24'h0, rx_exp_q.pop_front()});
        end
      end
      prev = resp_rdy;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", {31'h0, TX}, 32'h1);
    check("rst_cmd_sent", {31'h0, cmd_sent}, 32'h0);
    check("rst_resp_rdy", {31'h0, resp_rdy}, 32'h0);
    check("rst_resp", {24'h0, resp}, 32'h0);
`ifdef REMOTE_COMM_ACK_FLAG_EN
    check("rst_ack_ok", {31'h0, ack_ok}, 32'h0);
`endif
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // CAL packet, latency from start to cmd_sent
    send_pkt(CAL, 16'h0000);
    check("cmd_sent_clr", {31'h0, cmd_sent}, 32'h0);
    wait_sent(cyc);
    check("cmd_sent_latency", cyc, 32'd480);
    repeat (20) @(negedge clk);
    check("tx_queue_drained1", tx_exp_q.size(), 32'd0);
    check("cmd_sent_level", {31'h0, cmd_sent}, 32'h1);

    // ED BEEF with an ignored mid-packet request, response A5 received concurrently
    fork
      begin
        send_pkt(8'hED, 16'hBEEF);
        check("cmd_sent_clr2", {31'h0, cmd_sent}, 32'h0);
        repeat (100) @(negedge clk);
        cmd      = 8'h11;
        data     = 16'h2233;
        send_cmd = 1'b1;
        @(negedge clk);
        send_cmd = 1'b0;
        check("ignored_send", {31'h0, cmd_sent}, 32'h0);
        wait_sent(cyc);
        check("cmd_sent2", {31'h0, cmd_sent}, 32'h1);
      end
      begin
        repeat (40) @(negedge clk);
        drive_rx(POS_ACK);
      end
    join
    repeat (20) @(negedge clk);
    check("tx_queue_drained2", tx_exp_q.size(), 32'd0);
    check("rx_queue_drained1", rx_exp_q.size(), 32'd0);
    check("resp_rdy_set", {31'h0, resp_rdy}, 32'h1);
`ifdef REMOTE_COMM_ACK_FLAG_EN
    check("ack_ok_a5", {31'h0, ack_ok}, 32'h1);
`endif
    @(negedge clk);
    clr_resp_rdy = 1'b1;
    @(negedge clk);
    clr_resp_rdy = 1'b0;
    @(negedge clk);
    check("resp_rdy_clr", {31'h0, resp_rdy}, 32'h0);

    drive_rx(8'h5A);
    repeat (4) @(negedge clk);
    check("resp_rdy_5a", {31'h0, resp_rdy}, 32'h1);
    check("rx_queue_drained2", rx_exp_q.size(), 32'd0);
`ifdef REMOTE_COMM_ACK_FLAG_EN
    check("ack_ok_5a", {31'h0, ack_ok}, 32'h0);
`endif

    // 3-clock glitch: start detect clears resp_rdy, no byte follows
    RX = 1'b0;
    repeat (3) @(negedge clk);
    RX = 1'b1;
    repeat (60 * BAUD / 4) @(negedge clk);
    check("glitch_resp", {24'h0, resp}, 32'h5A);
    check("glitch_rdy", {31'h0, resp_rdy}, 32'h0);

    // Reset in the middle of the second byte
    send_pkt(STTHRST, 16'h1234);
    repeat (BAUD * 14) @(negedge clk);
    discard = 1'b1;
    tx_exp_q.delete();
    rst_n = 1'b0;
    #1;
    check("abort_tx", {31'h0, TX}, 32'h1);
    check("abort_cmd_sent", {31'h0, cmd_sent}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    while (discard && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    check("abort_frame_flushed", {31'h0, discard}, 32'h0);

    send_pkt(STYW, 16'hCAFE);
    wait_sent(cyc);
    check("cmd_sent_latency3", cyc, 32'd480);
    repeat (20) @(negedge clk);
    check("tx_queue_drained3", tx_exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
